// File: rtl/packet_unpacker_module.sv
// Receive-side frame unpacker: locks onto an alternating P0/P1 sync preamble plus zero padding,
// then recovers one word from the middle of each data block and emits them as one AXI-Stream packet.
module packet_unpacker_module #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_SAMPLES            = 100,
  parameter int NUM_DATA               = 4,
  parameter int SYNC_BLOCKS            = 4,
  parameter int PAD_BLOCKS             = 4,
  parameter int THRESH                 = 16384
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  sync_err,
  output logic [15:0]                           frame_count,
  output logic [2:0]                            led
);

  localparam int SC_W    = $clog2(NUM_SAMPLES);
  localparam int RUN_W   = $clog2(NUM_SAMPLES + 1);
  localparam int BLK_MAX = (SYNC_BLOCKS > PAD_BLOCKS)
                           ? ((SYNC_BLOCKS > NUM_DATA) ? SYNC_BLOCKS : NUM_DATA)
                           : ((PAD_BLOCKS > NUM_DATA) ? PAD_BLOCKS : NUM_DATA);
  localparam int BLK_W   = (BLK_MAX > 2) ? $clog2(BLK_MAX) : 1;

  localparam logic [SC_W-1:0]   SC_LAST    = SC_W'(NUM_SAMPLES - 1);
  localparam logic [SC_W-1:0]   SC_MID     = SC_W'(NUM_SAMPLES / 2);
  localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(NUM_SAMPLES - 1);
  localparam logic [BLK_W-1:0]  SYNC_LAST  = BLK_W'(SYNC_BLOCKS - 1);
  localparam logic [BLK_W-1:0]  PAD_LAST   = BLK_W'(PAD_BLOCKS - 1);
  localparam logic [BLK_W-1:0]  DATA_LAST  = BLK_W'(NUM_DATA - 1);
  localparam logic signed [16:0] THR_POS   = 17'(THRESH);
  localparam logic signed [16:0] THR_NEG   = -THR_POS;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    PAD  = 2'd2,
    DATA = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_P0,
    CLS_P1,
    CLS_ZERO,
    CLS_OTHER
  } cls_t;

  state_t                state, state_n;
  logic [SC_W-1:0]       sample_cnt, sample_n;
  logic [BLK_W-1:0]      block_cnt, block_n;
  logic [RUN_W-1:0]      run, run_n;
  logic                  expect_p1, expect_n;
  logic                  sync_err_n;
  logic                  valid_n, last_n;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_n;
  logic [15:0]           frame_n;

  logic                  accept;
  logic                  sample_wrap;
  logic signed [16:0]    i_ext, q_ext;
  logic                  i_in_band, q_in_band;
  cls_t                  cls;
  logic                  unused_inputs;

  assign unused_inputs = ^{s00_axis_tlast, s00_axis_tstrb};

  // Sign-extend both halves by one bit so THRESH itself compares without overflow.
  assign i_ext     = {s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1], s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1 -: 16]};
  assign q_ext     = {s00_axis_tdata[15], s00_axis_tdata[15:0]};
  assign i_in_band = (i_ext > THR_NEG) && (i_ext < THR_POS);
  assign q_in_band = (q_ext > THR_NEG) && (q_ext < THR_POS);

  always_comb begin
    if ((i_ext >= THR_POS) && q_in_band)      cls = CLS_P0;
    else if ((q_ext >= THR_POS) && i_in_band) cls = CLS_P1;
    else if (i_in_band && q_in_band)          cls = CLS_ZERO;
    else                                      cls = CLS_OTHER;
  end

  // Input stalls only when the next capture would overwrite a word still waiting downstream.
  assign s00_axis_tready = !((state == DATA) && (sample_cnt == SC_MID) && m00_axis_tvalid);
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign sample_wrap     = (sample_cnt == SC_LAST);

  assign m00_axis_tstrb  = '1;
  assign led             = {1'b0, state};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    sample_n   = sample_cnt;
    block_n    = block_cnt;
    run_n      = run;
    expect_n   = expect_p1;
    sync_err_n = 1'b0;
    valid_n    = m00_axis_tvalid;
    last_n     = m00_axis_tlast;
    data_n     = m00_axis_tdata;
    frame_n    = frame_count;

    if (m00_axis_tvalid && m00_axis_tready) begin
      valid_n = 1'b0;
      if (m00_axis_tlast) frame_n = frame_count + 16'd1;
    end

    if (accept) begin
      sample_n = sample_wrap ? '0 : sample_cnt + 1'b1;
      unique case (state)
        HUNT: begin
          sample_n = '0;
          if (cls == CLS_P0) begin
            if (run == RUN_LAST) begin
              state_n  = SYNC;
              block_n  = BLK_W'(1);
              expect_n = 1'b1;
              run_n    = '0;
            end else begin
              run_n = run + 1'b1;
            end
          end else begin
            run_n = '0;
          end
        end

        SYNC: begin
          if (cls != (expect_p1 ? CLS_P1 : CLS_P0)) begin
            state_n    = HUNT;
            sync_err_n = 1'b1;
            run_n      = (cls == CLS_P0) ? RUN_W'(1) : '0;
            sample_n   = '0;
            block_n    = '0;
          end else if (sample_wrap) begin
            expect_n = ~expect_p1;
            if (block_cnt == SYNC_LAST) begin
              state_n = PAD;
              block_n = '0;
            end else begin
              block_n = block_cnt + 1'b1;
            end
          end
        end

        PAD: begin
          if (cls != CLS_ZERO) begin
            state_n    = HUNT;
            sync_err_n = 1'b1;
            run_n      = (cls == CLS_P0) ? RUN_W'(1) : '0;
            sample_n   = '0;
            block_n    = '0;
          end else if (sample_wrap) begin
            if (block_cnt == PAD_LAST) begin
              state_n = DATA;
              block_n = '0;
            end else begin
              block_n = block_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (sample_cnt == SC_MID) begin
            valid_n = 1'b1;
            data_n  = C_M00_AXIS_TDATA_WIDTH'(s00_axis_tdata);
            last_n  = (block_cnt == DATA_LAST);
          end
          if (sample_wrap) begin
            if (block_cnt == DATA_LAST) begin
              state_n = HUNT;
              block_n = '0;
              run_n   = '0;
            end else begin
              block_n = block_cnt + 1'b1;
            end
          end
        end

        default: state_n = HUNT;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      // NOTE: the output word register is reset too, so a frame cut short by reset leaves nothing behind.
      state           <= HUNT;
      sample_cnt      <= '0;
      block_cnt       <= '0;
      run             <= '0;
      expect_p1       <= 1'b0;
      sync_err        <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      frame_count     <= '0;
    end else begin
      state           <= state_n;
      sample_cnt      <= sample_n;
      block_cnt       <= block_n;
      run             <= run_n;
      expect_p1       <= expect_n;
      sync_err        <= sync_err_n;
      m00_axis_tvalid <= valid_n;
      m00_axis_tlast  <= last_n;
      m00_axis_tdata  <= data_n;
      frame_count     <= frame_n;
    end
  end

endmodule

// File: tb/tb_packet_unpacker_module.sv
// Directed bench for packet_unpacker_module with 8-sample blocks: clean, corrupted, stalled,
// noisy, short-preamble and mid-frame-reset scenarios.
module tb_packet_unpacker_module;

  localparam int NS = 8;
  localparam logic [31:0] P0_C = 32'h4000_0000;  // I = THRESH exactly, Q = 0
  localparam logic [31:0] P1_C = 32'h0000_4000;  // Q = THRESH exactly, I = 0

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [3:0]  s_tstrb;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic [3:0]  m_tstrb;
  logic        sync_err;
  logic [15:0] frame_count;
  logic [2:0]  led;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_cnt;
  logic [32:0] got_q[$];
  logic [31:0] words[4] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};

  packet_unpacker_module #(
    .NUM_SAMPLES(NS), .NUM_DATA(4), .SYNC_BLOCKS(4), .PAD_BLOCKS(4), .THRESH(16384)
  ) dut (
    .s00_axis_aclk(clk),         .s00_axis_aresetn(rst_n),
    .s00_axis_tdata(s_tdata),    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast),    .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready),  .m00_axis_tready(m_tready),
    .m00_axis_tdata(m_tdata),    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast),    .m00_axis_tstrb(m_tstrb),
    .sync_err(sync_err),         .frame_count(frame_count),
    .led(led)
  );

  always #5 clk = ~clk;

  // Output handshakes and sync_err pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    if (sync_err) err_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) check("accept_timeout", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int i, input int q);
    return {i[15:0], q[15:0]};
  endfunction

  // kind: 0 = P0, 1 = P1, 2 = zero pad
  function automatic logic [31:0] sample_of(input int kind, input int idx, input bit noisy);
    if (!noisy) return (kind == 0) ? P0_C : (kind == 1) ? P1_C : 32'h0;
    case (kind)
      0:       return mk(20000, idx[0] ? -5000 : 5000);
      1:       return mk(-3000, 25000);
      default: return mk(idx[0] ? -1000 : 1000, idx[1] ? -1000 : 1000);
    endcase
  endfunction

  task automatic send_block(input int kind, input bit noisy);
    for (int i = 0; i < NS; i++) send(sample_of(kind, i, noisy));
  endtask

  task automatic send_data_block(input logic [31:0] w);
    for (int i = 0; i < NS; i++) send(w);
  endtask

  task automatic send_preamble(input bit noisy);
    send_block(0, noisy); send_block(1, noisy); send_block(0, noisy); send_block(1, noisy);
    for (int b = 0; b < 4; b++) send_block(2, noisy);
  endtask

  task automatic send_frame(input bit noisy);
    send_preamble(noisy);
    for (int b = 0; b < 4; b++) send_data_block(words[b]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_words(input string tag, input int base);
    logic [32:0] g;
    check({tag, "_count"}, 64'(got_q.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      g = (base + i < got_q.size()) ? got_q[base + i] : 'x;
      check({tag, "_word"}, 64'(g), 64'({i == 3, words[i]}));
    end
  endtask

  initial begin
    int base;
    int base2;
    int eb;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tstrb = '0; m_tready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_led", 64'(led), 64'd0);
    check("m_tstrb", 64'(m_tstrb), 64'hF);

    // Clean frame, with state and capture latency observed along the way.
    base = got_q.size(); eb = err_cnt;
    send_block(0, 1'b0);
    check("led_sync", 64'(led), 64'd1);
    send_block(1, 1'b0); send_block(0, 1'b0); send_block(1, 1'b0);
    check("led_pad", 64'(led), 64'd2);
    for (int b = 0; b < 4; b++) send_block(2, 1'b0);
    check("led_data", 64'(led), 64'd3);
    for (int i = 0; i < 4; i++) send(words[0]);
    check("pre_capture_valid", 64'(m_tvalid), 64'd0);
    send(words[0]);
    check("capture_valid", 64'(m_tvalid), 64'd1);
    check("capture_data", 64'(m_tdata), 64'(words[0]));
    check("capture_last", 64'(m_tlast), 64'd0);
    for (int i = 0; i < 3; i++) send(words[0]);
    for (int b = 1; b < 4; b++) send_data_block(words[b]);
    check("led_hunt_after", 64'(led), 64'd0);
    idle(3);
    check_words("clean", base);
    check("clean_frame_count", 64'(frame_count), 64'd1);
    check("clean_no_err", 64'(err_cnt - eb), 64'd0);

    // Corrupt sample 3 of sync block 2, then a clean frame.
    do_reset();
    base = got_q.size(); eb = err_cnt;
    send_block(0, 1'b0); send_block(1, 1'b0);
    for (int i = 0; i < NS; i++) begin
      send((i == 3) ? 32'h0 : P0_C);
      if (i == 3) begin
        check("corrupt_err_pulse", 64'(sync_err), 64'd1);
        check("corrupt_led", 64'(led), 64'd0);
      end
      if (i == 4) check("corrupt_err_drop", 64'(sync_err), 64'd0);
    end
    send_block(1, 1'b0);
    for (int b = 0; b < 4; b++) send_block(2, 1'b0);
    for (int b = 0; b < 4; b++) send_data_block(words[b]);
    idle(3);
    check("corrupt_no_output", 64'(got_q.size() - base), 64'd0);
    check("corrupt_err_once", 64'(err_cnt - eb), 64'd1);
    check("corrupt_led_hunt", 64'(led), 64'd0);
    send_frame(1'b0);
    idle(3);
    check_words("after_corrupt", base);
    check("after_corrupt_frames", 64'(frame_count), 64'd1);

    // Downstream held off for 20 cycles from the first word.
    do_reset();
    base = got_q.size();
    m_tready = 1'b0;
    send_preamble(1'b0);
    fork
      begin
        for (int b = 0; b < 4; b++) send_data_block(words[b]);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!m_tvalid && n < 200) begin
          n++;
          @(negedge clk);
        end
        if (!m_tvalid) check("bp_valid_timeout", 64'(m_tvalid), 64'd1);
        repeat (20) @(negedge clk);
        check("bp_s_tready_low", 64'(s_tready), 64'd0);
        check("bp_held_valid", 64'(m_tvalid), 64'd1);
        check("bp_held_data", 64'(m_tdata), 64'(words[0]));
        check("bp_held_last", 64'(m_tlast), 64'd0);
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    idle(3);
    check_words("backpressure", base);
    check("bp_frame_count", 64'(frame_count), 64'd1);

    // Noisy but in-class preamble and padding.
    do_reset();
    base = got_q.size();
    send_frame(1'b1);
    idle(3);
    check_words("noisy", base);
    check("noisy_frame_count", 64'(frame_count), 64'd1);

    // I one below THRESH is not P0; seven P0 samples are one short of lock.
    do_reset();
    base = got_q.size(); eb = err_cnt;
    for (int i = 0; i < NS; i++) send(mk(16383, 0));
    check("below_thresh_led", 64'(led), 64'd0);
    for (int i = 0; i < NS - 1; i++) send(P0_C);
    check("short_led_run", 64'(led), 64'd0);
    send_block(1, 1'b0);
    for (int b = 0; b < 4; b++) send_block(2, 1'b0);
    check("short_led_hunt", 64'(led), 64'd0);
    check("short_no_output", 64'(got_q.size() - base), 64'd0);
    check("short_no_err", 64'(err_cnt - eb), 64'd0);
    send_frame(1'b0);
    idle(3);
    check_words("after_short", base);
    check("after_short_frames", 64'(frame_count), 64'd1);

    // Reset asserted in data block 2 while its word is held.
    do_reset();
    base = got_q.size();
    send_preamble(1'b0);
    send_data_block(words[0]);
    send_data_block(words[1]);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(words[2]);
    check("pre_reset_valid", 64'(m_tvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(m_tvalid), 64'd0);
    check("async_rst_led", 64'(led), 64'd0);
    check("async_rst_data", 64'(m_tdata), 64'd0);
    #4 rst_n = 1'b1;
    m_tready = 1'b1;
    check("pre_reset_words", 64'(got_q.size() - base), 64'd2);
    base2 = got_q.size();
    idle(2);
    send_frame(1'b0);
    idle(3);
    check_words("after_reset", base2);
    check("after_reset_frames", 64'(frame_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
